fetch_stage: RTL

Front-end instruction fetch stage; sits directly upstream of the decode stage and feeds its instr/pc_in/valid_in/ready_in handshake.
- Holds the architectural fetch PC and issues one word request per cycle to a fixed-latency (1 cycle) instruction memory.
- Buffers returned words with their PCs in a small FIFO so decode back-pressure never drops an instruction.
- Accepts a redirect (branch/jump/mispredict) that flushes all buffered and in-flight fetches.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Holds the fetch PC, issues one word request per cycle to a 1-cycle-latency
// instruction memory, and buffers returned words with their PCs so decode
// back-pressure never drops an instruction. A redirect flushes everything.
// Optional build macro FETCH_PERF_EN adds stall/flush performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(BUF_DEPTH);

    logic [31:0] fetch_pc;
    logic [31:0] req_pc_q;
    logic        inflight;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [31:0] buf_instr [BUF_DEPTH];
    logic [31:0] buf_pc    [BUF_DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [AW+1:0] credit;
    logic          nonempty;

    // Handshake, credit check and head presentation.
    always_comb begin
        nonempty  = (count != '0);
        valid_out = nonempty && !redirect_valid;
        pop       = valid_out && ready_in;
        push      = inflight && !redirect_valid;
        // Entries held plus the word still in flight, minus the one leaving now.
        credit    = {1'b0, count} + (AW + 2)'(inflight) - (AW + 2)'(pop);
        issue     = !reset && !redirect_valid && (credit < DEPTH_W);
        imem_req  = issue;
        imem_addr = fetch_pc;
        instr     = nonempty ? buf_instr[head] : '0;
        pc_out    = nonempty ? buf_pc[head]    : '0;
    end

    // Fetch PC, in-flight tracking and buffer pointers; redirect has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc_q <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc_q <= fetch_pc;
            end
            inflight <= issue;
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage: capture the returning word with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[tail] <= imem_rdata;
            buf_pc[tail]    <= req_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters for decode stalls and redirect flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (valid_out && !ready_in && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
